uart_cfg_core: RTL and testbench

//  Parametrised full-duplex UART core: successor to the fixed 8N1 uart block.

---
 rtl/uart_cfg_core.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_cfg_core.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_core.sv
// uart_cfg_core: full-duplex UART with configurable data width, parity mode,
// stop-bit count and baud divisor. TX serialises a latched payload behind a
// start/done handshake; RX synchronises the pin, rejects false starts, and
// reports parity and framing errors alongside each received payload.
module uart_cfg_core #(
  parameter int DATA_BITS    = 8,   // 5..9, sent LSB first
  parameter int PARITY       = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS    = 1,   // 1 or 2
  parameter int CLKS_PER_BIT = 16   // >= 4, even
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_in,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_out,
  output logic                 rx_done,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam bit               HAS_PAR  = (PARITY != 0);
  localparam bit               ODD_PAR  = (PARITY == 2);
  localparam logic             STOP_LAST = (STOP_BITS == 2);  // index of final stop bit

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  // ---------------- transmitter ----------------
  tx_state_e              r_tx_state;
  logic [CNT_W-1:0]       r_tx_cnt;
  logic [IDX_W-1:0]       r_tx_idx;
  logic                   r_tx_stop;
  logic [DATA_BITS-1:0]   r_tx_shift;
  logic                   r_tx_par;
  logic                   r_tx;
  logic                   r_tx_busy;
  logic                   r_tx_done;
  logic                   w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == CNT_LAST);

  // TX frame sequencer: every output is registered so the pin never glitches.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_stop  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      if (r_tx_state != TX_IDLE) r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + CNT_W'(1);
      case (r_tx_state)
        TX_IDLE: begin
          if (tx_start) begin
            r_tx_shift <= tx_in;
            r_tx_par   <= (^tx_in) ^ ODD_PAR;
            r_tx_cnt   <= '0;
            r_tx       <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            r_tx       <= r_tx_shift[0];
            r_tx_idx   <= '0;
            r_tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            if (r_tx_idx == IDX_LAST) begin
              r_tx_stop <= 1'b0;
              if (HAS_PAR) begin
                r_tx       <= r_tx_par;
                r_tx_state <= TX_PAR;
              end else begin
                r_tx       <= 1'b1;
                r_tx_state <= TX_STOP;
              end
            end else begin
              r_tx_idx   <= r_tx_idx + IDX_W'(1);
              r_tx_shift <= r_tx_shift >> 1;
              r_tx       <= r_tx_shift[1];
            end
          end
        end
        TX_PAR: begin
          if (w_tx_bit_end) begin
            r_tx       <= 1'b1;
            r_tx_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (w_tx_bit_end) begin
            if (r_tx_stop == STOP_LAST) begin
              r_tx_busy  <= 1'b0;
              r_tx_done  <= 1'b1;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_stop <= 1'b1;
            end
          end
        end
        default: begin
          r_tx       <= 1'b1;
          r_tx_busy  <= 1'b0;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_tx_busy;
  assign tx_done = r_tx_done;

  // ---------------- receiver ----------------
  logic [1:0]             r_rx_sync;
  logic                   w_rx_s;
  rx_state_e              r_rx_state;
  logic [CNT_W-1:0]       r_rx_cnt;
  logic [IDX_W-1:0]       r_rx_idx;
  logic                   r_rx_stop;
  logic [DATA_BITS-1:0]   r_rx_shift;
  logic                   r_rx_par_bad;
  logic                   r_rx_ferr_acc;
  logic [DATA_BITS-1:0]   r_rx_out;
  logic                   r_rx_done;
  logic                   r_rx_perr;
  logic                   r_rx_ferr;
  logic                   w_rx_mid;

  // Two-flop synchroniser for the asynchronous rx pin.
  // NOTE: preset to 1 (line idle) so leaving reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_sync <= 2'b11;
    else        r_rx_sync <= {r_rx_sync[0], rx};
  end

  assign w_rx_s   = r_rx_sync[1];
  assign w_rx_mid = (r_rx_cnt == CNT_LAST);

  // RX frame sequencer: samples bit centres and publishes payload plus flags together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state    <= RX_IDLE;
      r_rx_cnt      <= '0;
      r_rx_idx      <= '0;
      r_rx_stop     <= 1'b0;
      r_rx_shift    <= '0;
      r_rx_par_bad  <= 1'b0;
      r_rx_ferr_acc <= 1'b0;
      r_rx_out      <= '0;
      r_rx_done     <= 1'b0;
      r_rx_perr     <= 1'b0;
      r_rx_ferr     <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_rx_s) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == CNT_HALF) begin
            r_rx_cnt <= '0;
            if (w_rx_s) begin
              r_rx_state <= RX_IDLE;           // too short: line glitch
            end else begin
              r_rx_idx     <= '0;
              r_rx_par_bad <= 1'b0;
              r_rx_state   <= RX_DATA;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (w_rx_mid) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rx_s, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_idx == IDX_LAST) begin
              r_rx_stop     <= 1'b0;
              r_rx_ferr_acc <= 1'b0;
              r_rx_state    <= HAS_PAR ? RX_PAR : RX_STOP;
            end else begin
              r_rx_idx <= r_rx_idx + IDX_W'(1);
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_PAR: begin
          if (w_rx_mid) begin
            r_rx_cnt     <= '0;
            r_rx_par_bad <= w_rx_s ^ (^r_rx_shift) ^ ODD_PAR;
            r_rx_state   <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (w_rx_mid) begin
            r_rx_cnt <= '0;
            if (r_rx_stop == STOP_LAST) begin
              r_rx_done  <= 1'b1;
              r_rx_out   <= r_rx_shift;
              r_rx_perr  <= r_rx_par_bad;
              r_rx_ferr  <= r_rx_ferr_acc | ~w_rx_s;
              // A low final stop bit means break or stuck line: wait for idle.
              r_rx_state <= w_rx_s ? RX_IDLE : RX_WAIT_HIGH;
            end else begin
              r_rx_stop     <= 1'b1;
              r_rx_ferr_acc <= ~w_rx_s;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (w_rx_s) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_out        = r_rx_out;
  assign rx_done       = r_rx_done;
  assign rx_parity_err = r_rx_perr;
  assign rx_frame_err  = r_rx_ferr;

endmodule

// File: tb/tb_uart_cfg_core.sv
// Bench for uart_cfg_core: instance A is 8N1, instance B is 8 data / odd
// parity / 2 stop. Each runs in loopback unless the bench takes over its rx
// line. Stimulus pushes expected frames into queues; monitors decode the tx
// pin at bit centres and pop expectations on every rx_done.
module tb_uart_cfg_core;
  localparam int CPB  = 16;
  localparam int FB_A = 10;
  localparam int FB_B = 12;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         t0;
  } rx_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_tx_start = 1'b0, b_tx_start = 1'b0;
  logic [7:0] a_tx_in = 8'h00, b_tx_in = 8'h00;
  logic       a_tx, a_tx_busy, a_tx_done, a_rx, a_rx_done, a_perr, a_ferr;
  logic       b_tx, b_tx_busy, b_tx_done, b_rx, b_rx_done, b_perr, b_ferr;
  logic [7:0] a_rx_out, b_rx_out;
  logic       a_drv = 1'b0, a_drv_val = 1'b1;
  logic       b_drv = 1'b0, b_drv_val = 1'b1;

  assign a_rx = a_drv ? a_drv_val : a_tx;
  assign b_rx = b_drv ? b_drv_val : b_tx;

  uart_cfg_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u_a (
    .clk(clk), .rst_n(rst_n), .tx_start(a_tx_start), .tx_in(a_tx_in),
    .tx(a_tx), .tx_busy(a_tx_busy), .tx_done(a_tx_done), .rx(a_rx),
    .rx_out(a_rx_out), .rx_done(a_rx_done), .rx_parity_err(a_perr), .rx_frame_err(a_ferr));

  uart_cfg_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_start(b_tx_start), .tx_in(b_tx_in),
    .tx(b_tx), .tx_busy(b_tx_busy), .tx_done(b_tx_done), .rx(b_rx),
    .rx_out(b_rx_out), .rx_done(b_rx_done), .rx_parity_err(b_perr), .rx_frame_err(b_ferr));

  logic [15:0] a_txq[$];
  logic [15:0] b_txq[$];
  rx_exp_t     a_rxq[$];
  rx_exp_t     b_rxq[$];
  int          a_starts[$];
  int          a_rx_cnt = 0;
  int          b_rx_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Serial frame, LSB = start bit, padded with idle-high beyond the stop bits.
  function automatic logic [15:0] make_frame(input logic [7:0] d, input int par);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = d[i];
    if (par == 1) f[9] = ($countones(d) % 2 == 1);
    if (par == 2) f[9] = ($countones(d) % 2 == 0);
    return f;
  endfunction

  task automatic push_rx(input bit sel, input logic [7:0] d, input logic pe,
                         input logic fe, input int t0);
    rx_exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.t0 = t0;
    if (sel) b_rxq.push_back(e);
    else     a_rxq.push_back(e);
  endtask

  task automatic wait_busy(input bit sel, input logic lvl);
    int n = 0;
    while ((sel ? b_tx_busy : a_tx_busy) !== lvl && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("busy_wait", sel ? b_tx_busy : a_tx_busy, lvl);
  endtask

  task automatic send(input bit sel, input logic [7:0] d);
    @(negedge clk);
    wait_busy(sel, 1'b0);
    @(negedge clk);
    if (sel) begin
      b_tx_in = d; b_tx_start = 1'b1; b_txq.push_back(make_frame(d, 2));
    end else begin
      a_tx_in = d; a_tx_start = 1'b1; a_txq.push_back(make_frame(d, 0));
    end
    push_rx(sel, d, 1'b0, 1'b0, -1);
    @(negedge clk);
    if (sel) begin b_tx_start = 1'b0; b_tx_in = 8'($urandom); end
    else     begin a_tx_start = 1'b0; a_tx_in = 8'($urandom); end
  endtask

  // Bench-driven rx frame; optional extra low time after the frame models a break.
  task automatic drive(input bit sel, input logic [15:0] bits, input int n, input int tail_low,
                       input logic [7:0] d, input logic pe, input logic fe);
    @(negedge clk);
    if (sel) begin b_drv_val = 1'b1; b_drv = 1'b1; end
    else     begin a_drv_val = 1'b1; a_drv = 1'b1; end
    @(negedge clk);
    push_rx(sel, d, pe, fe, cyc);
    for (int i = 0; i < n; i++) begin
      if (sel) b_drv_val = bits[i]; else a_drv_val = bits[i];
      repeat (CPB) @(negedge clk);
    end
    if (tail_low > 0) begin
      if (sel) b_drv_val = 1'b0; else a_drv_val = 1'b0;
      repeat (tail_low) @(negedge clk);
    end
    if (sel) b_drv_val = 1'b1; else a_drv_val = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    if (sel) b_drv = 1'b0; else a_drv = 1'b0;
  endtask

  // Decodes the tx pin independently of the DUT and checks frame timing.
  task automatic tx_monitor(input bit sel);
    int          fb;
    logic [15:0] got;
    logic [15:0] exp;
    bit          aborted;
    fb = sel ? FB_B : FB_A;
    forever begin
      @(negedge clk);
      if (rst_n && (sel ? b_tx : a_tx) === 1'b0) begin
        if (!sel) a_starts.push_back(cyc);
        got = '1;
        aborted = 1'b0;
        for (int c = 0; c <= fb * CPB; c++) begin
          if (c > 0) @(negedge clk);
          if (!rst_n) begin aborted = 1'b1; break; end
          if (c < fb * CPB && c % CPB == CPB / 2) begin
            got[c / CPB] = sel ? b_tx : a_tx;
            check("tx_busy_in_frame", sel ? b_tx_busy : a_tx_busy, 1);
            check("tx_done_early", sel ? b_tx_done : a_tx_done, 0);
          end
        end
        if (!aborted) begin
          check("tx_done_at_end", sel ? b_tx_done : a_tx_done, 1);
          check("tx_busy_at_end", sel ? b_tx_busy : a_tx_busy, 0);
          check("tx_idle_at_end", sel ? b_tx : a_tx, 1);
          check("tx_frame_expected", (sel ? b_txq.size() : a_txq.size()) > 0, 1);
          if ((sel ? b_txq.size() : a_txq.size()) > 0) begin
            exp = sel ? b_txq.pop_front() : a_txq.pop_front();
            check(sel ? "b_tx_frame_bits" : "a_tx_frame_bits", got, exp);
          end
        end
      end
    end
  endtask

  task automatic rx_monitor(input bit sel);
    rx_exp_t e;
    int      fb;
    int      lat;
    int      want;
    fb = sel ? FB_B : FB_A;
    want = (fb - 1) * CPB + CPB / 2 + 3;
    forever begin
      @(negedge clk);
      if (sel ? b_rx_done : a_rx_done) begin
        if (sel) b_rx_cnt++; else a_rx_cnt++;
        check("rx_done_expected", (sel ? b_rxq.size() : a_rxq.size()) > 0, 1);
        if ((sel ? b_rxq.size() : a_rxq.size()) > 0) begin
          e = sel ? b_rxq.pop_front() : a_rxq.pop_front();
          check(sel ? "b_rx_out" : "a_rx_out", sel ? b_rx_out : a_rx_out, e.data);
          check(sel ? "b_rx_parity_err" : "a_rx_parity_err", sel ? b_perr : a_perr, e.perr);
          check(sel ? "b_rx_frame_err" : "a_rx_frame_err", sel ? b_ferr : a_ferr, e.ferr);
          if (e.t0 >= 0) begin
            lat = cyc - e.t0;
            check("rx_latency", (lat >= want - 1 && lat <= want + 1) ? want : lat, want);
          end
        end
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] f;
    logic [7:0]  d;
    int          c0;
    fork
      tx_monitor(1'b0);
      tx_monitor(1'b1);
      rx_monitor(1'b0);
      rx_monitor(1'b1);
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_a_tx", a_tx, 1);           check("rst_b_tx", b_tx, 1);
    check("rst_a_busy", a_tx_busy, 0);    check("rst_b_busy", b_tx_busy, 0);
    check("rst_a_tx_done", a_tx_done, 0); check("rst_b_tx_done", b_tx_done, 0);
    check("rst_a_rx_out", a_rx_out, 0);   check("rst_b_rx_out", b_rx_out, 0);
    check("rst_a_rx_done", a_rx_done, 0); check("rst_b_rx_done", b_rx_done, 0);
    check("rst_a_perr", a_perr, 0);       check("rst_a_ferr", a_ferr, 0);
    check("rst_b_perr", b_perr, 0);       check("rst_b_ferr", b_ferr, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 loopback: directed byte then random bytes
    send(1'b0, 8'hA5);
    repeat (6) send(1'b0, 8'($urandom));

    // Odd parity, 2 stop bits loopback
    send(1'b1, 8'h03);
    repeat (4) send(1'b1, 8'($urandom));
    wait_busy(1'b1, 1'b0);
    repeat (20) @(negedge clk);

    // Flipped parity bit on B: payload still delivered, parity flag set
    f = make_frame(8'h03, 2);
    f[9] = ~f[9];
    drive(1'b1, f, FB_B, 0, 8'h03, 1'b1, 1'b0);
    // First of two stop bits low: framing error, line returns high normally
    d = 8'($urandom);
    f = make_frame(d, 2);
    f[10] = 1'b0;
    drive(1'b1, f, FB_B, 0, d, 1'b0, 1'b1);
    send(1'b1, 8'($urandom));

    // Break on A: stop bit low, line held low; exactly one rx_done
    wait_busy(1'b0, 1'b0);
    repeat (20) @(negedge clk);
    c0 = a_rx_cnt;
    f = make_frame(8'h3C, 0);
    f[9] = 1'b0;
    drive(1'b0, f, FB_A, 40, 8'h3C, 1'b0, 1'b1);
    check("break_single_rx_done", a_rx_cnt - c0, 1);
    send(1'b0, 8'($urandom));

    // 4-cycle glitch is rejected, following frame is clean
    wait_busy(1'b0, 1'b0);
    repeat (20) @(negedge clk);
    c0 = a_rx_cnt;
    a_drv_val = 1'b1; a_drv = 1'b1;
    @(negedge clk);
    a_drv_val = 1'b0;
    repeat (4) @(negedge clk);
    a_drv_val = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_no_rx_done", a_rx_cnt, c0);
    drive(1'b0, make_frame(8'h55, 0), FB_A, 0, 8'h55, 1'b0, 1'b0);

    // tx_start held high: three frames separated by one idle cycle
    wait_busy(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    c0 = a_starts.size();
    a_tx_in = 8'h11; a_tx_start = 1'b1;
    a_txq.push_back(make_frame(8'h11, 0)); push_rx(1'b0, 8'h11, 1'b0, 1'b0, -1);
    @(negedge clk);
    wait_busy(1'b0, 1'b1);
    a_tx_in = 8'h22;
    a_txq.push_back(make_frame(8'h22, 0)); push_rx(1'b0, 8'h22, 1'b0, 1'b0, -1);
    wait_busy(1'b0, 1'b0);
    wait_busy(1'b0, 1'b1);
    a_tx_in = 8'h33;
    a_txq.push_back(make_frame(8'h33, 0)); push_rx(1'b0, 8'h33, 1'b0, 1'b0, -1);
    wait_busy(1'b0, 1'b0);
    wait_busy(1'b0, 1'b1);
    a_tx_start = 1'b0;
    wait_busy(1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("b2b_frame_count", a_starts.size() - c0, 3);
    if (a_starts.size() - c0 >= 3) begin
      check("b2b_gap_1", a_starts[c0 + 1] - a_starts[c0], FB_A * CPB + 1);
      check("b2b_gap_2", a_starts[c0 + 2] - a_starts[c0 + 1], FB_A * CPB + 1);
    end

    // Reset during data bit 3: tx forced high at once, partial frame dropped
    repeat (10) @(negedge clk);
    a_tx_in = 8'h00; a_tx_start = 1'b1;
    @(negedge clk);
    a_tx_start = 1'b0;
    repeat (4 * CPB + CPB / 2 - 1) @(negedge clk);
    check("pre_rst_tx_low", a_tx, 0);
    check("pre_rst_busy", a_tx_busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_tx_high", a_tx, 1);
    check("rst_mid_busy_low", a_tx_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    c0 = a_rx_cnt;
    repeat (300) @(negedge clk);
    check("rst_mid_no_rx_done", a_rx_cnt, c0);
    send(1'b0, 8'hF0);

    // Drain and confirm every expectation was consumed
    wait_busy(1'b0, 1'b0);
    wait_busy(1'b1, 1'b0);
    repeat (200) @(negedge clk);
    check("a_txq_left", a_txq.size(), 0);
    check("b_txq_left", b_txq.size(), 0);
    check("a_rxq_left", a_rxq.size(), 0);
    check("b_rxq_left", b_rxq.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
